// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_issue_stage_pkg : shared widths, ALU opcodes, forwarding select |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_issue_stage_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_IDX_W  = 3;
    localparam int DEF_CTRL_W = 4;

    localparam logic [DEF_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [DEF_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [DEF_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [DEF_CTRL_W-1:0] ALU_SLL = 4'b0011;
    localparam logic [DEF_CTRL_W-1:0] ALU_SUB = 4'b0100;
    localparam logic [DEF_CTRL_W-1:0] ALU_SRL = 4'b0101;
    localparam logic [DEF_CTRL_W-1:0] ALU_MUL = 4'b0110;
    localparam logic [DEF_CTRL_W-1:0] ALU_XOR = 4'b0111;
    localparam logic [DEF_CTRL_W-1:0] ALU_SLT = 4'b1000;

    localparam logic [DEF_IDX_W-1:0] REG_ZERO = 3'd0;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_OUT = 2'd1,
        FWD_ISS = 2'd2
    } fwd_sel_e;

    // The issue slot holds the younger producer, so it wins over the output slot.
    function automatic fwd_sel_e fwd_select(input logic iss_hit, input logic out_hit);
        if (iss_hit)      return FWD_ISS;
        else if (out_hit) return FWD_OUT;
        else              return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_fwd_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_fwd_mux : 3-way priority operand bypass for one source index   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_fwd_mux
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic [IDX_W-1:0]  src_idx_i,
    input  logic [DATA_W-1:0] reg_val_i,
    input  logic              iss_valid_i,
    input  logic [IDX_W-1:0]  iss_rd_i,
    input  logic [DATA_W-1:0] iss_val_i,
    input  logic              out_valid_i,
    input  logic [IDX_W-1:0]  out_rd_i,
    input  logic [DATA_W-1:0] out_val_i,
    output logic [DATA_W-1:0] fwd_val_o
);

    logic     w_src_live;
    logic     w_iss_hit;
    logic     w_out_hit;
    fwd_sel_e w_sel;

    // r0 is hardwired zero, so it never takes a bypass.
    assign w_src_live = (src_idx_i != IDX_W'(REG_ZERO));
    assign w_iss_hit  = w_src_live && iss_valid_i && (iss_rd_i == src_idx_i);
    assign w_out_hit  = w_src_live && out_valid_i && (out_rd_i == src_idx_i);
    assign w_sel      = fwd_select(w_iss_hit, w_out_hit);

    always_comb begin
        fwd_val_o = reg_val_i;
        case (w_sel)
            FWD_ISS: fwd_val_o = iss_val_i;
            FWD_OUT: fwd_val_o = out_val_i;
            default: fwd_val_o = reg_val_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_issue_stage : issue + result slots around an external ALU,     |
// | with RAW bypass, flush and stall counter.  Rev 1.0                 |
// +--------------------------------------------------------------------+
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_rs1_idx,
    input  logic [IDX_W-1:0]  in_rs2_idx,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [DATA_W-1:0] in_rs2_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [IDX_W-1:0]  in_rd,
    input  logic [CTRL_W-1:0] in_alu_control,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [IDX_W-1:0]  out_rd,
    output logic [7:0]        stall_count
);

    localparam logic [7:0] C_STALL_MAX = 8'hFF;

    logic              iss_valid_q, iss_valid_d;
    logic [IDX_W-1:0]  iss_rd_q,    iss_rd_d;
    logic [DATA_W-1:0] alu_in1_q,   alu_in1_d;
    logic [DATA_W-1:0] alu_in2_q,   alu_in2_d;
    logic [CTRL_W-1:0] alu_ctrl_q,  alu_ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_res_q,   out_res_d;
    logic              out_zero_q,  out_zero_d;
    logic [IDX_W-1:0]  out_rd_q,    out_rd_d;
    logic [7:0]        stall_q,     stall_d;

    logic              w_adv;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2_reg;
    logic [DATA_W-1:0] w_src2;

    // Whenever an accept happens the issue slot is emptying, so its live ALU result is the bypass value.
    alu_fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_fwd_rs1 (
        .src_idx_i   (in_rs1_idx),
        .reg_val_i   (in_rs1_val),
        .iss_valid_i (iss_valid_q),
        .iss_rd_i    (iss_rd_q),
        .iss_val_i   (alu_result),
        .out_valid_i (out_valid_q),
        .out_rd_i    (out_rd_q),
        .out_val_i   (out_res_q),
        .fwd_val_o   (w_src1)
    );

    alu_fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_fwd_rs2 (
        .src_idx_i   (in_rs2_idx),
        .reg_val_i   (in_rs2_val),
        .iss_valid_i (iss_valid_q),
        .iss_rd_i    (iss_rd_q),
        .iss_val_i   (alu_result),
        .out_valid_i (out_valid_q),
        .out_rd_i    (out_rd_q),
        .out_val_i   (out_res_q),
        .fwd_val_o   (w_src2_reg)
    );

    assign w_src2     = in_use_imm ? in_imm : w_src2_reg;
    assign w_adv      = iss_valid_q && (!out_valid_q || out_ready);
    assign w_in_ready = !flush && (!iss_valid_q || w_adv);
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_rd_d    = iss_rd_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        alu_ctrl_d  = alu_ctrl_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_zero_d  = out_zero_q;
        out_rd_d    = out_rd_q;
        stall_d     = stall_q;

        if (flush) begin
            iss_valid_d = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (w_accept) begin
                iss_valid_d = 1'b1;
                iss_rd_d    = in_rd;
                alu_in1_d   = w_src1;
                alu_in2_d   = w_src2;
                alu_ctrl_d  = in_alu_control;
            end else if (w_adv) begin
                iss_valid_d = 1'b0;
            end

            if (w_adv) begin
                out_valid_d = 1'b1;
                out_res_d   = alu_result;
                out_zero_d  = alu_zero;
                out_rd_d    = iss_rd_q;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end

        if (in_valid && !w_in_ready && (stall_q != C_STALL_MAX)) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_rd_q    <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_ctrl_q  <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_zero_q  <= 1'b0;
            out_rd_q    <= '0;
            stall_q     <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_rd_q    <= iss_rd_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_ctrl_q  <= alu_ctrl_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_zero_q  <= out_zero_d;
            out_rd_q    <= out_rd_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready    = w_in_ready;
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_control = alu_ctrl_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_res_q;
    assign out_zero    = out_zero_q;
    assign out_rd      = out_rd_q;
    assign stall_count = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_issue_stage : random + directed scoreboard bench against an |
// | in-order architectural model.  Rev 1.0                             |
// +--------------------------------------------------------------------+
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_rs1_idx, in_rs2_idx;
    logic [3:0] in_rs1_val, in_rs2_val;
    logic [3:0] in_imm;
    logic       in_use_imm;
    logic [2:0] in_rd;
    logic [3:0] in_alu_control;
    logic [3:0] alu_in1, alu_in2, alu_control;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_zero;
    logic [2:0] out_rd;
    logic [7:0] stall_count;

    typedef struct {
        logic [3:0] res;
        logic       z;
        logic [2:0] rd;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] rf   [8];
    logic [3:0] spec [8];
    logic [3:0] ops  [9];
    int         checks;
    int         errors;
    int         model_stall;
    logic       last_acc;
    logic       last_flush;
    logic [3:0] last_op1, last_op2, last_ctrl;

    alu_issue_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1_idx     (in_rs1_idx),
        .in_rs2_idx     (in_rs2_idx),
        .in_rs1_val     (in_rs1_val),
        .in_rs2_val     (in_rs2_val),
        .in_imm         (in_imm),
        .in_use_imm     (in_use_imm),
        .in_rd          (in_rd),
        .in_alu_control (in_alu_control),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .alu_control    (alu_control),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_zero       (out_zero),
        .out_rd         (out_rd),
        .stall_count    (stall_count)
    );

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic [7:0] p;
        p = {4'd0, a} * {4'd0, b};
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
            ALU_SLL: return a << b;
            ALU_SRL: return a >> b;
            ALU_MUL: return p[3:0];
            ALU_XOR: return a ^ b;
            default: return 4'd0;
        endcase
    endfunction

    // External combinational ALU and register-file read ports
    always_comb begin
        alu_result = alu_fn(alu_in1, alu_in2, alu_control);
        alu_zero   = (alu_result == 4'd0);
    end
    assign in_rs1_val = rf[in_rs1_idx];
    assign in_rs2_val = rf[in_rs2_idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the oldest expected result whenever writeback takes one.
    initial begin
        exp_t e;
        logic wr;
        for (int i = 0; i < 8; i++) rf[i] = 4'(i);
        forever begin
            @(negedge clk);
            #3;
            wr = 1'b0;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %0h rd %0d expected none", out_result, out_rd);
                end else begin
                    e = sb.pop_front();
                    check("out_result", 32'(out_result), 32'(e.res));
                    check("out_zero",   32'(out_zero),   32'(e.z));
                    check("out_rd",     32'(out_rd),     32'(e.rd));
                    wr = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (wr && e.rd != 3'd0) rf[e.rd] = e.res;
        end
    end

    task automatic step(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [3:0] imm, input logic ui, input logic [2:0] rd,
                        input logic [3:0] op, input logic fl, input logic ordy);
        logic       exp_ready;
        logic [3:0] op1, op2, r;
        @(negedge clk);
        if (last_acc) begin
            check("alu_in1",     32'(alu_in1),     32'(last_op1));
            check("alu_in2",     32'(alu_in2),     32'(last_op2));
            check("alu_control", 32'(alu_control), 32'(last_ctrl));
        end
        if (last_flush) check("out_valid_after_flush", 32'(out_valid), 32'd0);
        check("stall_count", 32'(stall_count), 32'(model_stall));
        in_valid       = v;
        in_rs1_idx     = rs1;
        in_rs2_idx     = rs2;
        in_imm         = imm;
        in_use_imm     = ui;
        in_rd          = rd;
        in_alu_control = op;
        flush          = fl;
        out_ready      = fl ? 1'b0 : ordy;
        #1;
        exp_ready = !fl && (sb.size() < 2 || out_ready);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        last_acc   = v && exp_ready;
        last_flush = fl;
        if (v && !exp_ready && model_stall < 255) model_stall++;
        if (fl) begin
            sb.delete();
            spec = rf;
        end else if (last_acc) begin
            op1 = spec[rs1];
            op2 = ui ? imm : spec[rs2];
            r   = alu_fn(op1, op2, op);
            sb.push_back('{res: r, z: (r == 4'd0), rd: rd});
            if (rd != 3'd0) spec[rd] = r;
            last_op1  = op1;
            last_op2  = op2;
            last_ctrl = op;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_in_ready",    32'(in_ready),    32'd1);
        check("rst_alu_in1",     32'(alu_in1),     32'd0);
        check("rst_alu_in2",     32'(alu_in2),     32'd0);
        check("rst_alu_control", 32'(alu_control), 32'd0);
        check("rst_out_result",  32'(out_result),  32'd0);
        check("rst_out_zero",    32'(out_zero),    32'd0);
        check("rst_out_rd",      32'(out_rd),      32'd0);
        check("rst_stall_count", 32'(stall_count), 32'd0);
        sb.delete();
        spec        = rf;
        model_stall = 0;
        last_acc    = 1'b0;
        last_flush  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; model_stall = 0;
        last_acc = 1'b0; last_flush = 1'b0;
        last_op1 = '0; last_op2 = '0; last_ctrl = '0;
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRL, ALU_MUL, ALU_XOR};
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rs1_idx = '0; in_rs2_idx = '0; in_imm = '0; in_use_imm = 1'b0;
        in_rd = '0; in_alu_control = '0;
        pulse_reset();

        // Back-to-back dependency: r1 = 3+4, r2 = r1+1
        step(1, 3'd3, 3'd4, 4'd0, 0, 3'd1, ALU_ADD, 0, 1);
        step(1, 3'd1, 3'd0, 4'd1, 1, 3'd2, ALU_ADD, 0, 1);
        step(0, 0, 0, 0, 0, 0, ALU_AND, 0, 1);
        // Gap-1 dependency through the output slot
        step(1, 3'd5, 3'd0, 4'd0, 1, 3'd3, ALU_XOR, 0, 1);
        step(0, 0, 0, 0, 0, 0, ALU_AND, 0, 1);
        step(1, 3'd3, 3'd0, 4'd0, 0, 3'd4, ALU_SUB, 0, 1);
        // Producer targeting r0 must not be forwarded
        step(1, 3'd0, 3'd0, 4'd4, 1, 3'd0, ALU_ADD, 0, 1);
        step(1, 3'd0, 3'd0, 4'd0, 0, 3'd7, ALU_ADD, 0, 1);
        // Wrap to zero and SLT
        step(1, 3'd0, 3'd0, 4'hF, 1, 3'd1, ALU_ADD, 0, 1);
        step(1, 3'd1, 3'd0, 4'd1, 1, 3'd2, ALU_ADD, 0, 1);
        step(1, 3'd0, 3'd0, 4'd2, 1, 3'd3, ALU_ADD, 0, 1);
        step(1, 3'd3, 3'd0, 4'd5, 1, 3'd4, ALU_SLT, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, ALU_AND, 0, 1);
        // Backpressure with both slots full and in_valid held
        step(1, 3'd1, 3'd2, 4'd0, 0, 3'd5, ALU_OR,  0, 0);
        step(1, 3'd5, 3'd3, 4'd0, 0, 3'd6, ALU_ADD, 0, 0);
        repeat (3) step(1, 3'd6, 3'd5, 4'd0, 0, 3'd7, ALU_SUB, 0, 0);
        step(1, 3'd6, 3'd5, 4'd0, 0, 3'd7, ALU_SUB, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, ALU_AND, 0, 1);
        // Flush with both slots valid and a pending instruction
        step(1, 3'd2, 3'd3, 4'd0, 0, 3'd1, ALU_ADD, 0, 0);
        step(1, 3'd1, 3'd3, 4'd0, 0, 3'd2, ALU_ADD, 0, 0);
        step(1, 3'd2, 3'd1, 4'd0, 0, 3'd3, ALU_MUL, 1, 1);
        step(1, 3'd2, 3'd1, 4'd0, 0, 3'd3, ALU_MUL, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, ALU_AND, 0, 1);
        // Asynchronous reset with work in flight
        step(1, 3'd4, 3'd5, 4'd0, 0, 3'd6, ALU_XOR, 0, 0);
        step(1, 3'd6, 3'd5, 4'd0, 0, 3'd7, ALU_OR,  0, 0);
        pulse_reset();
        step(1, 3'd7, 3'd6, 4'd0, 0, 3'd1, ALU_ADD, 0, 1);
        // Saturation of stall_count
        step(1, 3'd1, 3'd1, 4'd0, 0, 3'd2, ALU_ADD, 0, 0);
        step(1, 3'd2, 3'd1, 4'd0, 0, 3'd3, ALU_ADD, 0, 0);
        repeat (262) step(1, 3'd3, 3'd2, 4'd0, 0, 3'd4, ALU_SUB, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, ALU_AND, 0, 1);
        pulse_reset();

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), ops[$urandom_range(0, 8)],
                 ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        repeat (6) step(0, 0, 0, 0, 0, 0, ALU_AND, 0, 1);
        check("drain_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
